// File: rtl/seq_div_core.sv
// Restoring shift-subtract divider: one quotient bit per clock, signed or unsigned operands,
// with a single start/done handshake and results held until the next completion.
module seq_div_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic            neg_q;
  logic            neg_r;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] quot_final;
  logic [WIDTH-1:0] rem_final;

  // The kept partial remainder is always below the divisor magnitude, so only the shifted
  // value needs the extra top bit; the register itself stays WIDTH bits wide.
  always_comb begin
    dividend_neg = signed_i & dividend_i[WIDTH-1];
    divisor_neg  = signed_i & divisor_i[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend_i : dividend_i;
    divisor_mag  = divisor_neg ? -divisor_i : divisor_i;
    shifted      = {rem, dvd[WIDTH-1]};
    trial        = shifted - {1'b0, dsr};
    q_bit        = ~trial[WIDTH];
    rem_next     = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next     = {dvd[WIDTH-2:0], q_bit};
    quot_final   = neg_q ? -dvd_next : dvd_next;
    rem_final    = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (divisor_i == '0) begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              div_zero_o  <= 1'b1;
              done_o      <= 1'b1;
              state       <= DONE;
            end else begin
              neg_q <= dividend_neg ^ divisor_neg;
              neg_r <= dividend_neg;
              dvd   <= dividend_mag;
              dsr   <= divisor_mag;
              rem   <= '0;
              count <= CNT_INIT;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          dvd   <= dvd_next;
          count <= count - CW'(1);
          // Final bit lands this edge, so the outputs take the sign-corrected next values.
          if (count == CW'(1)) begin
            quotient_o  <= quot_final;
            remainder_o <= rem_final;
            div_zero_o  <= 1'b0;
            done_o      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
